// File: rtl/fetch_queue.sv
// Instruction buffer between F and D: in-order {pc, instr} FIFO with a valid/ready
// handshake on both sides and a branch flush.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             br_en,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_instr,
    output logic             f_ready,
    input  logic             d_ready,
    output logic             fd_valid,
    output logic [31:0]      fd_pc,
    output logic [31:0]      fd_instr,
    output logic [PTR_W:0]   q_count
);

    localparam logic [31:0]    NOP_INSTR = 32'h0000_0013;
    localparam logic [PTR_W:0] FULL      = (PTR_W + 1)'(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic             flush;
    logic [PTR_W-1:0] ptr_diff;

    // Handshake terms depend only on registered occupancy, so D never reaches F.
    always_comb begin
        f_ready  = (count != FULL);
        fd_valid = (count != '0);
        push     = f_valid & f_ready;
        pop      = fd_valid & d_ready;
        flush    = reset | br_en;
        q_count  = count;
        ptr_diff = wr_ptr - rd_ptr;
        fd_pc    = 32'h0;
        fd_instr = NOP_INSTR;
        if (fd_valid) begin
            fd_pc    = pc_mem[rd_ptr];
            fd_instr = instr_mem[rd_ptr];
        end
    end

    // Pointer and occupancy state; flush wins over any same-cycle push or pop.
    always_ff @(posedge clock) begin
        if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage has no reset; contents outside the live window are don't-care.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= f_pc;
            instr_mem[wr_ptr] <= f_instr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count <= FULL)
                else $error("fetch_queue: count exceeds DEPTH");
            assert ((count == {1'b0, ptr_diff}) || ((count == FULL) && (ptr_diff == '0)))
                else $error("fetch_queue: count inconsistent with pointers");
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clock;
    logic             reset;
    logic             br_en;
    logic             f_valid;
    logic [31:0]      f_pc;
    logic [31:0]      f_instr;
    logic             f_ready;
    logic             d_ready;
    logic             fd_valid;
    logic [31:0]      fd_pc;
    logic [31:0]      fd_instr;
    logic [PTR_W:0]   q_count;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .br_en    (br_en),
        .f_valid  (f_valid),
        .f_pc     (f_pc),
        .f_instr  (f_instr),
        .f_ready  (f_ready),
        .d_ready  (d_ready),
        .fd_valid (fd_valid),
        .fd_pc    (fd_pc),
        .fd_instr (fd_instr),
        .q_count  (q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        r;
        logic        b;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        dr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eins;
        logic [2:0]  ecnt;
        logic        efr;
    } vec_t;

    ent_t mq[$];
    vec_t tbl[10];
    int   checks = 0;
    int   passed = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk(input string nm, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eins, input logic [2:0] ecnt, input logic efr);
        cmp({nm, ".fd_valid"}, 32'(fd_valid), 32'(ev));
        cmp({nm, ".fd_pc"},    fd_pc,         epc);
        cmp({nm, ".fd_instr"}, fd_instr,      eins);
        cmp({nm, ".q_count"},  32'(q_count),  32'(ecnt));
        cmp({nm, ".f_ready"},  32'(f_ready),  32'(efr));
    endtask

    // Expected outputs derived purely from the reference queue contents.
    task automatic chk_model(input string nm);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eins;
        ev   = (mq.size() != 0);
        epc  = ev ? mq[0].pc    : 32'h0;
        eins = ev ? mq[0].instr : NOP;
        chk(nm, ev, epc, eins, 3'(mq.size()), 1'(mq.size() < DEPTH));
    endtask

    // Drive one cycle of inputs, advance the reference model at the edge, settle at negedge.
    task automatic cycle(input logic r, input logic b, input logic fv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic dr);
        bit do_pop;
        bit do_push;
        reset = r; br_en = b; f_valid = fv; f_pc = pc; f_instr = ins; d_ready = dr;
        @(posedge clock);
        if (r || b) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && dr;
            do_push = fv && (mq.size() < DEPTH);
            if (do_pop)  mq.delete(0);
            if (do_push) mq.push_back('{pc: pc, instr: ins});
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; br_en = 1'b0; f_valid = 1'b0; f_pc = '0; f_instr = '0; d_ready = 1'b0;
        @(negedge clock);

        // r b fv pc ins dr | ev epc eins cnt fr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   NOP,          3'd0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h100, 32'h00500093, 1'b0, 1'b1, 32'h100, 32'h00500093, 3'd1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,   NOP,          3'd0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h100, 32'hA100,     1'b0, 1'b1, 32'h100, 32'hA100,     3'd1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h104, 32'hA104,     1'b0, 1'b1, 32'h100, 32'hA100,     3'd2, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h108, 32'hA108,     1'b0, 1'b1, 32'h100, 32'hA100,     3'd3, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h10C, 32'hA10C,     1'b0, 1'b1, 32'h100, 32'hA100,     3'd4, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h110, 32'hA110,     1'b0, 1'b1, 32'h100, 32'hA100,     3'd4, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h110, 32'hA110,     1'b1, 1'b1, 32'h104, 32'hA104,     3'd3, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 32'h110, 32'hA110,     1'b0, 1'b1, 32'h104, 32'hA104,     3'd4, 1'b0};

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].r, tbl[i].b, tbl[i].fv, tbl[i].pc, tbl[i].ins, tbl[i].dr);
            chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eins, tbl[i].ecnt, tbl[i].efr);
        end

        // Steady stream: one entry in flight, PCs emerge in order across two pointer wraps.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'(4 * k), 32'h5000 + 32'(k), 1'b1);
            chk($sformatf("stream%0d", k), 1'b1, 32'(4 * k), 32'h5000 + 32'(k), 3'd1, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("stream_drain", 1'b0, 32'h0, NOP, 3'd0, 1'b1);

        // Flush with simultaneous push and pop.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 32'h10 + 32'(4 * k), 32'h7000 + 32'(k), 1'b0);
        chk("pre_flush", 1'b1, 32'h10, 32'h7000, 3'd3, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h300, 32'h7300, 1'b1);
        chk("flush", 1'b0, 32'h0, NOP, 3'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("flush_idle", 1'b0, 32'h0, NOP, 3'd0, 1'b1);

        // Reset mid-operation with a push pending.
        for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 1'b1, 32'h40 + 32'(4 * k), 32'h8000 + 32'(k), 1'b0);
        chk("pre_reset", 1'b1, 32'h40, 32'h8000, 3'd2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h400, 32'h8400, 1'b0);
        chk("mid_reset", 1'b0, 32'h0, NOP, 3'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h200, 32'h8200, 1'b0);
        chk("post_reset_push", 1'b1, 32'h200, 32'h8200, 3'd1, 1'b1);

        // Randomized traffic against the reference queue.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 5),
                  1'($urandom_range(0, 99) < 70), $urandom, $urandom,
                  1'($urandom_range(0, 99) < 55));
            chk_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
